// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the 1-to-2 stream demultiplexer
package demux_pkg;

    localparam int CNT_W         = 16;
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/demux1to2_stream_if.sv
// rtl/demux1to2_stream_if.sv - input stream plus two output streams of the demultiplexer
interface demux1to2_stream_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    modport master (
        output in_valid, in_sel, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

endinterface

// File: rtl/stream_slot.sv
// rtl/stream_slot.sv - one-entry holding register for a single output channel
module stream_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // A full slot that is draining this cycle can take a new word in the same cycle.
    assign free      = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1to2_stream.sv
// rtl/demux1to2_stream.sv - 1-to-2 stream demux, tagged or deinterleave; DEMUX_STREAM_CNT_EN adds handshake counters
module demux1to2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ALT   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    demux1to2_stream_if.slave    bus
`ifdef DEMUX_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1
`endif
);

    chan_t dest;
    chan_t ptr_q;
    logic  free0;
    logic  free1;
    logic  slot_free;
    logic  accept;
    logic  load0;
    logic  load1;

    assign dest      = (ALT != 0) ? ptr_q : chan_t'(bus.in_sel);
    assign slot_free = (dest == CH1) ? free1 : free0;
    assign bus.in_ready = !rst && slot_free;
    assign accept    = bus.in_valid && bus.in_ready;
    assign load0     = accept && (dest == CH0);
    assign load1     = accept && (dest == CH1);

    // The pointer only advances on an accepted word, so a stalled channel freezes the stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= CH0;
        end else if (accept && (ALT != 0)) begin
            ptr_q <= (ptr_q == CH0) ? CH1 : CH0;
        end
    end

    stream_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (load0),
        .load_data (bus.in_data),
        .out_ready (bus.out0_ready),
        .out_valid (bus.out0_valid),
        .out_data  (bus.out0_data),
        .free      (free0)
    );

    stream_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (load1),
        .load_data (bus.in_data),
        .out_ready (bus.out1_ready),
        .out_valid (bus.out1_valid),
        .out_data  (bus.out1_data),
        .free      (free1)
    );

`ifdef DEMUX_STREAM_CNT_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (bus.out0_valid && bus.out0_ready) cnt0_q <= sat_inc(cnt0_q);
            if (bus.out1_valid && bus.out1_ready) cnt1_q <= sat_inc(cnt1_q);
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule
